// File: rtl/stage_fetch_queued.sv
// Fetch stage: PC generator, in-order imem request/response handshake, and instruction queue toward decode.
// Response reaches decode one cycle later. Optional FETCH_PERF_EN adds stall, redirect and drop counters.

// Generic circular FIFO with synchronous flush. The caller never pushes when full or pops when empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

module stage_fetch_queued #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 1,
  parameter int              QDEPTH   = 4,
  parameter int              MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] new_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_redirect_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int OCW = $clog2(MAX_OUT + 1);

  logic [XLEN-1:0]   fetch_pc;
  logic [OCW-1:0]    inflight;
  logic [OCW-1:0]    drop_cnt;
  logic [QCW-1:0]    q_count;
  logic [XLEN-1:0]   tag_pc;
  logic [XLEN-1:0]   head_pc;
  logic [XLEN-1:0]   head_inst;
  logic              credit_ok;
  logic              accept;
  logic              resp;
  logic              drop_resp;
  logic              q_push;
  logic              q_pop;

  // Queue slots are reserved at issue time, so every in-flight response (even a stale one) holds a slot.
  assign credit_ok = ((32'(q_count) + 32'(inflight)) < 32'(QDEPTH)) && (inflight < OCW'(MAX_OUT));

  assign imem_req_valid = !reset && !branch_taken && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign resp      = imem_resp_valid && !reset && (inflight != '0);
  // A response landing in the redirect cycle itself belongs to the old path as well.
  assign drop_resp = resp && ((drop_cnt != '0) || branch_taken);
  assign q_push    = resp && !drop_resp;

  assign inst_valid = !reset && (q_count != '0);
  assign q_pop      = inst_valid && inst_ready;
  assign inst_out   = inst_valid ? head_inst : '0;
  assign out_pc     = inst_valid ? head_pc   : RESET_PC;

  // Tag FIFO occupancy is exactly the number of outstanding requests.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (1'b0),
    .push     (accept),
    .push_dat (fetch_pc),
    .pop      (resp),
    .head_dat (tag_pc),
    .count    (inflight)
  );

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (QDEPTH)
  ) u_inst_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (branch_taken),
    .push     (q_push),
    .push_dat ({tag_pc, imem_resp_data}),
    .pop      (q_pop),
    .head_dat ({head_pc, head_inst}),
    .count    (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (branch_taken) begin
      fetch_pc <= new_pc;
    end else if (accept) begin
      fetch_pc <= fetch_pc + XLEN'(PC_INC);
    end
  end

  // On redirect every response still pending after this cycle is stale; nothing is issued that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (branch_taken) begin
      drop_cnt <= inflight - OCW'(resp);
    end else if (resp && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - OCW'(1);
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
      perf_drop_cnt     <= '0;
    end else begin
      perf_stall_cnt    <= sat_inc(perf_stall_cnt, !inst_valid);
      perf_redirect_cnt <= sat_inc(perf_redirect_cnt, branch_taken);
      perf_drop_cnt     <= sat_inc(perf_drop_cnt, drop_resp);
    end
  end
`endif

endmodule

// File: tb/tb_stage_fetch_queued.sv
// Bench for stage_fetch_queued: vector table, redirect/stall sequences, and a randomized run against a stream model.
module tb_stage_fetch_queued;

  localparam int          QDEPTH   = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset, branch_taken, imem_req_ready, imem_resp_valid, inst_ready;
  logic [31:0] new_pc, imem_resp_data;
  logic        imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, inst_out, out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_redirect_cnt, perf_drop_cnt;
  logic [31:0] w_stall, w_redir, w_drop;
  int          m_stall, m_redir, m_drop;
`endif

  logic        rst4;
  logic        r4_req_valid, r4_inst_valid;
  logic [31:0] r4_req_addr, r4_inst_out, r4_out_pc;

  always #5 clk = ~clk;

  stage_fetch_queued #(.XLEN(32), .RESET_PC(RESET_PC), .PC_INC(1), .QDEPTH(QDEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .new_pc(new_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  // Byte-addressed instance starting just below the 32-bit wrap point; memory never answers it.
  stage_fetch_queued #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_INC(4), .QDEPTH(QDEPTH), .MAX_OUT(MAX_OUT)) dut4 (
    .clk(clk), .reset(rst4), .branch_taken(1'b0), .new_pc(32'h0),
    .imem_req_valid(r4_req_valid), .imem_req_ready(1'b1), .imem_req_addr(r4_req_addr),
    .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
    .inst_valid(r4_inst_valid), .inst_ready(1'b0), .inst_out(r4_inst_out), .out_pc(r4_out_pc)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(w_stall), .perf_redirect_cnt(w_redir), .perf_drop_cnt(w_drop)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    bit          rst;
    bit          mem_rdy;
    bit          inst_rdy;
    bit          e_req_vld;
    logic [31:0] e_addr;
    bit          e_inst_vld;
    logic [31:0] e_pc;
  } vec_t;

  mreq_t       mq[$];
  vec_t        vecs[$];
  int          checks = 0, passes = 0;
  int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  int          epoch = 0, occ = 0, drops = 0, delivered = 0;
  logic [31:0] exp_pc, exp_req;
  logic        s_req_vld, s_inst_vld;
  logic [31:0] s_req_addr, s_inst_out, s_out_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic vec_t mk(bit r, bit mr, bit ir, bit rv, int a, bit iv, int p);
    return vec_t'{r, mr, ir, rv, 32'(a), iv, 32'(p)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One clock cycle: entered at a falling edge with the fetch-side inputs already driven.
  task automatic step();
    int   n_out, lat, due;
    logic stale;
    n_out           = mq.size();
    stale           = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (reset) begin
      mq.delete();
    end else if (n_out > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_of(mq[0].addr);
      stale           = (mq[0].epoch != epoch) || branch_taken;
      mq.delete(0);
    end
    #1;
    s_req_vld  = imem_req_valid;
    s_req_addr = imem_req_addr;
    s_inst_vld = inst_valid;
    s_inst_out = inst_out;
    s_out_pc   = out_pc;
    if (reset) begin
      chk("rst_req_valid", 32'(s_req_vld), 32'd0);
      chk("rst_inst_valid", 32'(s_inst_vld), 32'd0);
      chk("rst_inst_out", s_inst_out, 32'd0);
      chk("rst_out_pc", s_out_pc, RESET_PC);
      occ      = 0;
      epoch++;
      exp_pc   = RESET_PC;
      exp_req  = RESET_PC;
      last_due = 0;
`ifdef FETCH_PERF_EN
      m_stall = 0; m_redir = 0; m_drop = 0;
`endif
    end else begin
      chk("issue_rule", 32'(s_req_vld), 32'(!branch_taken && (occ + n_out) < QDEPTH && n_out < MAX_OUT));
      if (s_req_vld) chk("req_addr", s_req_addr, exp_req);
      chk("inst_valid", 32'(s_inst_vld), 32'(occ > 0));
      if (s_inst_vld) begin
        chk("out_pc", s_out_pc, exp_pc);
        chk("inst_out", s_inst_out, inst_of(exp_pc));
      end
`ifdef FETCH_PERF_EN
      chk("perf_stall", perf_stall_cnt, 32'(m_stall));
      chk("perf_redirect", perf_redirect_cnt, 32'(m_redir));
      chk("perf_drop", perf_drop_cnt, 32'(m_drop));
      if (!s_inst_vld) m_stall++;
      if (branch_taken) m_redir++;
      if (imem_resp_valid && stale) m_drop++;
`endif
      if (s_req_vld && imem_req_ready) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        mq.push_back(mreq_t'{s_req_addr, due, epoch});
        exp_req = exp_req + 32'd1;
      end
      if (s_inst_vld && inst_ready) begin
        exp_pc = exp_pc + 32'd1;
        occ--;
        delivered++;
      end
      if (imem_resp_valid) begin
        if (stale) drops++;
        else occ++;
      end
      if (branch_taken) begin
        occ     = 0;
        epoch++;
        exp_pc  = new_pc;
        exp_req = new_pc;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    bit got;
    int d0;
    reset = 1'b1; rst4 = 1'b1; branch_taken = 1'b0; new_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    exp_pc = RESET_PC; exp_req = RESET_PC;
`ifdef FETCH_PERF_EN
    m_stall = 0; m_redir = 0; m_drop = 0;
`endif

    // Byte-addressed wrap: 0xFFFFFFFC then 0x00000000, then MAX_OUT blocks a third request.
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    chk("wrap_first_valid", 32'(r4_req_valid), 32'd1);
    chk("wrap_first_addr", r4_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_next_valid", 32'(r4_req_valid), 32'd1);
    chk("wrap_next_addr", r4_req_addr, 32'h0000_0000);
    @(negedge clk); #1;
    chk("wrap_maxout_block", 32'(r4_req_valid), 32'd0);
    @(negedge clk);

    // Streaming from reset, then a 10-cycle decode stall from reset and its release.
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 2, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 3, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 4, 1, 2));
    vecs.push_back(mk(0, 1, 1, 1, 5, 1, 3));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 3, 1, 0));
    for (int i = 4; i < 10; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 4, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 5, 1, 2));
    vecs.push_back(mk(0, 1, 1, 1, 6, 1, 3));
    vecs.push_back(mk(0, 1, 1, 1, 7, 1, 4));

    lat_min = 1; lat_max = 1;
    foreach (vecs[i]) begin
      reset          = vecs[i].rst;
      imem_req_ready = vecs[i].mem_rdy;
      inst_ready     = vecs[i].inst_rdy;
      branch_taken   = 1'b0;
      step();
      chk($sformatf("tbl%0d_req_valid", i), 32'(s_req_vld), 32'(vecs[i].e_req_vld));
      if (vecs[i].e_req_vld) chk($sformatf("tbl%0d_req_addr", i), s_req_addr, vecs[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), 32'(s_inst_vld), 32'(vecs[i].e_inst_vld));
      if (vecs[i].e_inst_vld) begin
        chk($sformatf("tbl%0d_out_pc", i), s_out_pc, vecs[i].e_pc);
        chk($sformatf("tbl%0d_inst_out", i), s_inst_out, inst_of(vecs[i].e_pc));
      end
    end

    // Redirect to 0x40 with a non-empty queue and two requests in flight.
    reset = 1'b1; step(); reset = 1'b0;
    lat_min = 3; lat_max = 3; inst_ready = 1'b0; imem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("redir_pending", 32'(mq.size()), 32'd2);
    chk("redir_queue_busy", 32'(s_inst_vld), 32'd1);
    d0 = drops;
    branch_taken = 1'b1; new_pc = 32'h40;
    step();
    branch_taken = 1'b0;
    step();
    chk("redir_flush", 32'(s_inst_vld), 32'd0);
    inst_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      step();
      if (s_inst_vld) got = 1'b1;
    end
    chk("redir_arrival", 32'(got), 32'd1);
    if (got) chk("redir_first_pc", s_out_pc, 32'h40);
    chk("redir_drops", 32'(drops - d0), 32'd2);
`ifdef FETCH_PERF_EN
    chk("redir_perf_redirect", perf_redirect_cnt, 32'd1);
    chk("redir_perf_drop", perf_drop_cnt, 32'd2);
`endif

    // Memory back-pressure: address must hold while valid and not ready.
    reset = 1'b1; step(); reset = 1'b0;
    lat_min = 1; lat_max = 1; inst_ready = 1'b1; imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_valid", 32'(s_req_vld), 32'd1);
      chk("hold_addr", s_req_addr, RESET_PC);
    end
    imem_req_ready = 1'b1;
    step();
    chk("hold_accept_addr", s_req_addr, RESET_PC);
    step();
    chk("hold_advance_addr", s_req_addr, RESET_PC + 32'd1);

    // Randomized traffic with redirects and mid-stream resets.
    lat_min = 1; lat_max = 4; delivered = 0;
    for (int k = 0; k < 2500; k++) begin
      reset          = ($urandom_range(299, 0) == 0);
      branch_taken   = ($urandom_range(39, 0) == 0);
      new_pc         = $urandom();
      imem_req_ready = ($urandom_range(9, 0) < 7);
      inst_ready     = ($urandom_range(9, 0) < 6);
      step();
    end
    reset = 1'b0; branch_taken = 1'b0;
    chk("random_progress", 32'(delivered > 300), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
